axis_frame_arb: RTL

AXIS_FRAME_ARB -- requirements
Module: axis_frame_arb

---
 rtl/axis_frame_arb.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/axis_frame_arb.sv
// axis_frame_arb: merges PORTS AXI-Stream inputs, granting whole frames.
// Round-robin by default; define AXIS_FRAME_ARB_FIXED_PRIO_EN for lowest-index-wins.
module axis_frame_arb #(
   parameter int PORTS      = 4,
   parameter int DATA_WIDTH = 32,
   parameter int KEEP_WIDTH = DATA_WIDTH/8,
   parameter int USER_WIDTH = 1,
   localparam int SEL_WIDTH = $clog2(PORTS)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [PORTS*KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic [PORTS-1:0]            s_axis_tvalid,
   output logic [PORTS-1:0]            s_axis_tready,
   input  logic [PORTS-1:0]            s_axis_tlast,
   input  logic [PORTS*USER_WIDTH-1:0] s_axis_tuser,
   output logic [DATA_WIDTH-1:0]       m_axis_tdata,
   output logic [KEEP_WIDTH-1:0]       m_axis_tkeep,
   output logic                        m_axis_tvalid,
   input  logic                        m_axis_tready,
   output logic                        m_axis_tlast,
   output logic [USER_WIDTH-1:0]       m_axis_tuser,
   output logic [SEL_WIDTH-1:0]        m_axis_tid,
   output logic                        grant_valid,
   output logic [SEL_WIDTH-1:0]        grant_index
);

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   localparam logic [SEL_WIDTH-1:0] LAST_PORT = SEL_WIDTH'(PORTS-1);

   state_t                 state_q, state_d;
   logic [SEL_WIDTH-1:0]   grant_q, grant_d;
   logic [SEL_WIDTH-1:0]   rr_q, rr_d;
   logic [SEL_WIDTH-1:0]   winner;
   logic                   m_valid_q, m_valid_d;
   logic [DATA_WIDTH-1:0]  data_q;
   logic [KEEP_WIDTH-1:0]  keep_q;
   logic                   last_q;
   logic [USER_WIDTH-1:0]  user_q;
   logic [SEL_WIDTH-1:0]   tid_q;

   logic                   sel_valid, sel_last;
   logic [DATA_WIDTH-1:0]  sel_data;
   logic [KEEP_WIDTH-1:0]  sel_keep;
   logic [USER_WIDTH-1:0]  sel_user;
   logic                   active, out_ready, accept;

   // First requester at or after start, wrapping: smallest forward distance wins.
   function automatic logic [SEL_WIDTH-1:0] rr_pick(
      input logic [PORTS-1:0]     req,
      input logic [SEL_WIDTH-1:0] start
   );
      int best;
      int d;
      rr_pick = start;
      best    = PORTS;
      for (int i = 0; i < PORTS; i++) begin
         d = i - int'(start);
         if (d < 0) d = d + PORTS;
         if (req[i] && d < best) begin
            best    = d;
            rr_pick = SEL_WIDTH'(i);
         end
      end
   endfunction

   assign active    = (state_q == ACTIVE) && !rst;
   assign out_ready = !m_valid_q || m_axis_tready;
   assign accept    = active && sel_valid && out_ready;
   assign winner    = rr_pick(s_axis_tvalid, rr_q);

   // Route the granted input's beat onto a single set of wires.
   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      sel_keep  = '0;
      sel_user  = '0;
      for (int i = 0; i < PORTS; i++) begin
         if (grant_q == SEL_WIDTH'(i)) begin
            sel_valid = s_axis_tvalid[i];
            sel_last  = s_axis_tlast[i];
            sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            sel_keep  = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
            sel_user  = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
         end
      end
   end

   // Only the granted port sees tready, and only when the output slot frees.
   always_comb begin
      s_axis_tready = '0;
      for (int i = 0; i < PORTS; i++) begin
         s_axis_tready[i] = active && out_ready &&
                            (grant_q == SEL_WIDTH'(i));
      end
   end

   // Grant FSM: pick a winner from IDLE, hold it until its tlast is taken.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      rr_d    = rr_q;
      unique case (state_q)
         IDLE: begin
            if (|s_axis_tvalid) begin
               state_d = ACTIVE;
               grant_d = winner;
            end
         end
         ACTIVE: begin
            if (accept && sel_last) begin
               state_d = IDLE;
`ifdef AXIS_FRAME_ARB_FIXED_PRIO_EN
               rr_d    = '0;
`else
               rr_d    = (grant_q == LAST_PORT) ? '0 : grant_q + 1'b1;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output slot fills on accept, drains when taken with nothing behind it.
   always_comb begin
      m_valid_d = m_valid_q;
      if (accept) begin
         m_valid_d = 1'b1;
      end else if (m_axis_tready) begin
         m_valid_d = 1'b0;
      end
   end

   // Control state, cleared by the synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         rr_q      <= '0;
         m_valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         rr_q      <= rr_d;
         m_valid_q <= m_valid_d;
      end
   end

   // Payload register; its contents are meaningless while m_valid_q is low.
   always_ff @(posedge clk) begin
      if (accept) begin
         data_q <= sel_data;
         keep_q <= sel_keep;
         last_q <= sel_last;
         user_q <= sel_user;
         tid_q  <= grant_q;
      end
   end

   assign m_axis_tdata  = data_q;
   assign m_axis_tkeep  = keep_q;
   assign m_axis_tlast  = last_q;
   assign m_axis_tuser  = user_q;
   assign m_axis_tid    = tid_q;
   assign m_axis_tvalid = m_valid_q && !rst;
   assign grant_valid   = active;
   assign grant_index   = rst ? '0 : grant_q;

endmodule
